// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel window scan controller.
package sobel_pkg;

  typedef enum logic [1:0] {
    DIR_LOAD  = 2'b00,
    DIR_LEFT  = 2'b01,
    DIR_RIGHT = 2'b10,
    DIR_DOWN  = 2'b11
  } shift_dir_t;

  typedef enum logic [2:0] {
    StIdle,
    StFullLoad,
    StCalc,
    StWaitCalc,
    StShift,
    StRefill,
    StDone
  } scan_state_t;

  localparam int unsigned FULL_FILL = 9;
  localparam int unsigned REFILL    = 3;

endpackage

// File: rtl/scan_addr_gen.sv
// Pixel address for fill index k of the current window load or refill.
module scan_addr_gen import sobel_pkg::*; #(
  parameter int unsigned IMG_W  = 8,
  parameter int unsigned ADDR_W = 16
) (
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] win_row,
  input  logic [ADDR_W-1:0] win_col,
  input  shift_dir_t        dir,
  input  logic [3:0]        k,
  output logic [ADDR_W-1:0] addr
);

  logic [3:0]        k_div3;
  logic [3:0]        k_mod3;
  logic [ADDR_W-1:0] row;
  logic [ADDR_W-1:0] col;

  assign k_div3 = k / 4'd3;
  assign k_mod3 = k % 4'd3;

  // Refill coordinates assume win_row/win_col already reflect the shift.
  always_comb begin
    row = win_row;
    col = win_col;
    unique case (dir)
      DIR_LOAD: begin
        row = win_row + ADDR_W'(k_div3);
        col = win_col + ADDR_W'(k_mod3);
      end
      DIR_LEFT: begin
        row = win_row + ADDR_W'(k);
        col = win_col + ADDR_W'(2);
      end
      DIR_RIGHT: begin
        row = win_row + ADDR_W'(k);
      end
      DIR_DOWN: begin
        row = win_row + ADDR_W'(2);
        col = win_col + ADDR_W'(k);
      end
    endcase
  end

  assign addr = base + row * ADDR_W'(IMG_W) + col;

endmodule

// File: rtl/window_scan_ctrl.sv
// Serpentine scan controller: loads the 3x3 window buffer, then shifts and
// refills it across the frame, pulsing the compute stage once per window.
module window_scan_ctrl import sobel_pkg::*; #(
  parameter int unsigned IMG_W  = 8,
  parameter int unsigned IMG_H  = 8,
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              frame_start,
  input  logic [ADDR_W-1:0] frame_base,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rd_ack,
  output logic              wb_start_read,
  output logic              wb_start_shift,
  output logic [1:0]        wb_shift_direc,
  output logic [3:0]        wb_count,
  output logic              calc_start,
  input  logic              calc_done,
  output logic [ADDR_W-1:0] win_row,
  output logic [ADDR_W-1:0] win_col,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [ADDR_W-1:0] LastRow    = ADDR_W'(IMG_H - 3);
  localparam logic [ADDR_W-1:0] EndCol     = ADDR_W'(IMG_W - 3);
  localparam logic [3:0]        LastFull   = 4'(FULL_FILL - 1);
  localparam logic [3:0]        LastRefill = 4'(REFILL - 1);

  scan_state_t       state_q, state_d;
  shift_dir_t        dir_q, dir_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] row_q, row_d;
  logic [ADDR_W-1:0] col_q, col_d;
  logic [3:0]        k_q, k_d;
  logic [ADDR_W-1:0] gen_addr;
  logic              row_end;
  logic              last_win;
  logic              reading;

  // Even rows sweep left-to-right, odd rows right-to-left.
  assign row_end  = row_q[0] ? (col_q == '0) : (col_q == EndCol);
  assign last_win = (row_q == LastRow) && row_end;
  assign reading  = (state_q == StFullLoad) || (state_q == StRefill);

  scan_addr_gen #(
    .IMG_W  (IMG_W),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .base    (base_q),
    .win_row (row_q),
    .win_col (col_q),
    .dir     (dir_q),
    .k       (k_q),
    .addr    (gen_addr)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= StIdle;
      dir_q   <= DIR_LOAD;
      base_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      base_q  <= base_d;
      row_q   <= row_d;
      col_q   <= col_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    base_d  = base_q;
    row_d   = row_q;
    col_d   = col_q;
    k_d     = k_q;
    unique case (state_q)
      StIdle: begin
        if (frame_start) begin
          base_d  = frame_base;
          row_d   = '0;
          col_d   = '0;
          dir_d   = DIR_LOAD;
          k_d     = '0;
          state_d = StFullLoad;
        end
      end
      StFullLoad: begin
        if (mem_rd_ack) begin
          if (k_q == LastFull) begin
            k_d     = '0;
            state_d = StCalc;
          end else begin
            k_d = k_q + 4'd1;
          end
        end
      end
      StCalc: state_d = StWaitCalc;
      StWaitCalc: begin
        if (calc_done) begin
          if (last_win) begin
            state_d = StDone;
          end else begin
            state_d = StShift;
            if (row_end)       dir_d = DIR_DOWN;
            else if (row_q[0]) dir_d = DIR_RIGHT;
            else               dir_d = DIR_LEFT;
          end
        end
      end
      StShift: begin
        k_d     = '0;
        state_d = StRefill;
        case (dir_q)
          DIR_LEFT:  col_d = col_q + ADDR_W'(1);
          DIR_RIGHT: col_d = col_q - ADDR_W'(1);
          DIR_DOWN:  row_d = row_q + ADDR_W'(1);
          default:   ;
        endcase
      end
      StRefill: begin
        if (mem_rd_ack) begin
          if (k_q == LastRefill) begin
            k_d     = '0;
            state_d = StCalc;
          end else begin
            k_d = k_q + 4'd1;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_rd_req     = reading;
    mem_addr       = reading ? gen_addr : '0;
    wb_start_read  = reading & mem_rd_ack;
    wb_start_shift = (state_q == StShift);
    wb_shift_direc = dir_q;
    wb_count       = reading ? k_q : 4'd0;
    calc_start     = (state_q == StCalc);
    frame_done     = (state_q == StDone);
    busy           = (state_q != StIdle) && (state_q != StDone);
  end

  assign win_row = row_q;
  assign win_col = col_q;

endmodule

// File: tb/tb_window_scan_ctrl.sv
// Directed bench: 4x4 scan with ack/calc timing variations, plus a 3x3 instance.
module tb_window_scan_ctrl;

  localparam int unsigned AW = 16;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          frame_start = 1'b0;
  logic [AW-1:0] frame_base = '0;
  logic          mem_rd_ack = 1'b0;
  logic          calc_done = 1'b0;
  logic          mem_rd_req, wb_start_read, wb_start_shift, calc_start, busy, frame_done;
  logic [AW-1:0] mem_addr, win_row, win_col;
  logic [1:0]    wb_shift_direc;
  logic [3:0]    wb_count;

  logic          s_frame_start = 1'b0;
  logic [AW-1:0] s_frame_base = '0;
  logic          s_ack = 1'b0;
  logic          s_calc_done = 1'b0;
  logic          s_req, s_start_read, s_start_shift, s_calc_start, s_busy, s_frame_done;
  logic [AW-1:0] s_addr, s_win_row, s_win_col;
  logic [1:0]    s_direc;
  logic [3:0]    s_count;

  always #5 clk = ~clk;

  window_scan_ctrl #(.IMG_W(4), .IMG_H(4), .ADDR_W(AW)) u_dut (
    .clk (clk), .n_rst (n_rst), .frame_start (frame_start), .frame_base (frame_base),
    .mem_rd_req (mem_rd_req), .mem_addr (mem_addr), .mem_rd_ack (mem_rd_ack),
    .wb_start_read (wb_start_read), .wb_start_shift (wb_start_shift),
    .wb_shift_direc (wb_shift_direc), .wb_count (wb_count), .calc_start (calc_start),
    .calc_done (calc_done), .win_row (win_row), .win_col (win_col), .busy (busy),
    .frame_done (frame_done)
  );

  window_scan_ctrl #(.IMG_W(3), .IMG_H(3), .ADDR_W(AW)) u_dut_small (
    .clk (clk), .n_rst (n_rst), .frame_start (s_frame_start), .frame_base (s_frame_base),
    .mem_rd_req (s_req), .mem_addr (s_addr), .mem_rd_ack (s_ack),
    .wb_start_read (s_start_read), .wb_start_shift (s_start_shift),
    .wb_shift_direc (s_direc), .wb_count (s_count), .calc_start (s_calc_start),
    .calc_done (s_calc_done), .win_row (s_win_row), .win_col (s_win_col), .busy (s_busy),
    .frame_done (s_frame_done)
  );

  logic [59:0] all_outs, s_all_outs;
  assign all_outs = {mem_rd_req, mem_addr, wb_start_read, wb_start_shift, wb_shift_direc,
                     wb_count, calc_start, win_row, win_col, busy, frame_done};
  assign s_all_outs = {s_req, s_addr, s_start_read, s_start_shift, s_direc, s_count,
                       s_calc_start, s_win_row, s_win_col, s_busy, s_frame_done};

  int checks = 0;
  int failures = 0;

  logic [AW-1:0] addr_log[$];
  int            cnt_log[$];
  int            dir_log[$];
  int n_calc, n_done, n_overlap, n_unstable, n_badread, n_gapbad, n_busybad;
  int n_wait, n_stray, n_restart;

  logic [AW-1:0] exp_addr [18] = '{16'h100, 16'h101, 16'h102, 16'h104, 16'h105, 16'h106,
                                   16'h108, 16'h109, 16'h10A, 16'h103, 16'h107, 16'h10B,
                                   16'h10D, 16'h10E, 16'h10F, 16'h104, 16'h108, 16'h10C};
  int exp_cnt [18] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 0, 1, 2, 0, 1, 2, 0, 1, 2};
  int exp_dir [3]  = '{1, 3, 2};

  // Drives one 4x4 frame: ack after `delay` waiting cycles, calc_done `hold` cycles into
  // WAIT_CALC, optional stray calc_done during the first load, optional frame_start
  // re-pulse while busy. Stops at frame_done, after `abort_at` reads, or on a cycle budget.
  task automatic run_frame(input logic [AW-1:0] base, input int delay, input int hold,
                           input bit stray, input bit restart, input int abort_at);
    int since, wait_ctr, last_calc;
    logic prev_wait;
    logic [AW-1:0] prev_addr;
    logic [3:0] prev_cnt;
    bit fin, restarted;
    addr_log.delete(); cnt_log.delete(); dir_log.delete();
    n_calc = 0; n_done = 0; n_overlap = 0; n_unstable = 0; n_badread = 0;
    n_gapbad = 0; n_busybad = 0; n_wait = 0; n_stray = 0; n_restart = 0;
    since = -1; wait_ctr = 0; last_calc = 0; prev_wait = 1'b0; prev_addr = '0;
    prev_cnt = '0; fin = 1'b0; restarted = 1'b0;
    @(posedge clk); #1;
    frame_start = 1'b1;
    frame_base  = base;
    for (int cyc = 0; cyc < 1000 && !fin; cyc++) begin
      @(posedge clk); #1;
      frame_start = 1'b0;
      frame_base  = 16'hDEAD;
      if (restart && !restarted && addr_log.size() == 5) begin
        frame_start = 1'b1;
        frame_base  = 16'h0200;
        restarted   = 1'b1;
        n_restart++;
      end
      if (mem_rd_req) begin
        if (wait_ctr == delay) begin
          mem_rd_ack = 1'b1;
          wait_ctr = 0;
        end else begin
          mem_rd_ack = 1'b0;
          wait_ctr++;
        end
      end else begin
        mem_rd_ack = 1'b0;
      end
      if (since >= 0) begin
        since++;
        calc_done = (since == hold + 1);
        if (calc_done) since = -1;
      end else begin
        calc_done = stray && mem_rd_req && (n_calc == 0);
        if (calc_done) n_stray++;
      end
      @(negedge clk);
      if (wb_start_read) begin
        addr_log.push_back(mem_addr);
        cnt_log.push_back(int'(wb_count));
      end
      if (wb_start_read !== mem_rd_ack) n_badread++;
      if (prev_wait && (mem_addr !== prev_addr || wb_count !== prev_cnt)) n_unstable++;
      if (mem_rd_req && !mem_rd_ack) n_wait++;
      prev_wait = mem_rd_req && !mem_rd_ack;
      prev_addr = mem_addr;
      prev_cnt  = wb_count;
      if (wb_start_read && wb_start_shift) n_overlap++;
      if (wb_start_shift) begin
        dir_log.push_back(int'(wb_shift_direc));
        if (cyc - last_calc != hold + 2) n_gapbad++;
      end
      if (calc_start) begin
        n_calc++;
        last_calc = cyc;
        since = 0;
      end
      if (frame_done) begin
        n_done++;
        fin = 1'b1;
        if (busy !== 1'b0) n_busybad++;
        if (cyc - last_calc != hold + 2) n_gapbad++;
      end else if (busy !== 1'b1) begin
        n_busybad++;
      end
      if (abort_at > 0 && addr_log.size() == abort_at) fin = 1'b1;
    end
    mem_rd_ack = 1'b0;
    calc_done  = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if (all_outs !== '0) begin
      failures++;
      $display("FAIL reset_outs: got %0h expected 0", all_outs);
    end
    checks++;
    if (s_all_outs !== '0) begin
      failures++;
      $display("FAIL reset_outs_small: got %0h expected 0", s_all_outs);
    end
    #2 n_rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (all_outs !== '0) begin
      failures++;
      $display("FAIL idle_outs: got %0h expected 0", all_outs);
    end
  endtask

  task automatic test_scan_4x4;
    logic [AW-1:0] a;
    int c;
    run_frame(16'h0100, 0, 0, 1'b0, 1'b0, 0);
    checks++;
    if (n_done !== 1) begin failures++; $display("FAIL scan_done: got %0d expected 1", n_done); end
    checks++;
    if (addr_log.size() !== 18) begin
      failures++; $display("FAIL scan_reads: got %0d expected 18", addr_log.size());
    end
    for (int i = 0; i < 18; i++) begin
      a = (i < addr_log.size()) ? addr_log[i] : 16'hFFFF;
      c = (i < cnt_log.size()) ? cnt_log[i] : -1;
      checks++;
      if (a !== exp_addr[i] || c != exp_cnt[i]) begin
        failures++;
        $display("FAIL scan_read[%0d]: got addr %0h count %0d expected addr %0h count %0d",
                 i, a, c, exp_addr[i], exp_cnt[i]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      c = (i < dir_log.size()) ? dir_log[i] : -1;
      checks++;
      if (c != exp_dir[i]) begin
        failures++; $display("FAIL scan_dir[%0d]: got %0d expected %0d", i, c, exp_dir[i]);
      end
    end
    checks++;
    if (dir_log.size() != 3) begin
      failures++; $display("FAIL scan_shifts: got %0d expected 3", dir_log.size());
    end
    checks++;
    if (n_calc != 4) begin failures++; $display("FAIL scan_calcs: got %0d expected 4", n_calc); end
    checks++;
    if (n_overlap + n_badread + n_gapbad + n_busybad != 0) begin
      failures++;
      $display("FAIL scan_protocol: got overlap %0d badread %0d gap %0d busy %0d expected 0",
               n_overlap, n_badread, n_gapbad, n_busybad);
    end
    checks++;
    if (win_row !== 16'd1 || win_col !== 16'd0) begin
      failures++;
      $display("FAIL scan_last_win: got (%0d,%0d) expected (1,0)", win_row, win_col);
    end
    @(negedge clk);
    checks++;
    if ({mem_rd_req, busy, frame_done, calc_start} !== 4'b0) begin
      failures++;
      $display("FAIL scan_after_done: got %b expected 0000",
               {mem_rd_req, busy, frame_done, calc_start});
    end
  endtask

  task automatic test_single_window;
    logic [AW-1:0] a_log[$];
    int calcs, shifts, dones;
    calcs = 0; shifts = 0; dones = 0;
    @(posedge clk); #1;
    s_frame_start = 1'b1; s_frame_base = 16'h0040; s_ack = 1'b1; s_calc_done = 1'b1;
    for (int c = 0; c < 60 && dones == 0; c++) begin
      @(posedge clk); #1;
      s_frame_start = 1'b0; s_frame_base = 16'h0000;
      @(negedge clk);
      if (s_start_read) a_log.push_back(s_addr);
      if (s_start_shift) shifts++;
      if (s_calc_start) calcs++;
      if (s_frame_done) dones++;
    end
    s_ack = 1'b0; s_calc_done = 1'b0;
    checks++;
    if (a_log.size() != 9) begin
      failures++; $display("FAIL small_reads: got %0d expected 9", a_log.size());
    end
    for (int i = 0; i < 9 && i < a_log.size(); i++) begin
      checks++;
      if (a_log[i] !== 16'h0040 + 16'(i)) begin
        failures++;
        $display("FAIL small_addr[%0d]: got %0h expected %0h", i, a_log[i], 16'h0040 + 16'(i));
      end
    end
    checks++;
    if (calcs != 1 || shifts != 0 || dones != 1) begin
      failures++;
      $display("FAIL small_counts: got calc %0d shift %0d done %0d expected 1 0 1",
               calcs, shifts, dones);
    end
  endtask

  task automatic test_ack_delay;
    logic [AW-1:0] a;
    run_frame(16'h0100, 3, 0, 1'b0, 1'b0, 0);
    checks++;
    if (n_done !== 1) begin failures++; $display("FAIL delay_done: got %0d expected 1", n_done); end
    checks++;
    if (n_wait != 54) begin failures++; $display("FAIL delay_waits: got %0d expected 54", n_wait); end
    checks++;
    if (n_unstable != 0 || n_badread != 0) begin
      failures++;
      $display("FAIL delay_stable: got unstable %0d badread %0d expected 0 0",
               n_unstable, n_badread);
    end
    checks++;
    if (addr_log.size() !== 18) begin
      failures++; $display("FAIL delay_reads: got %0d expected 18", addr_log.size());
    end
    for (int i = 0; i < 18; i++) begin
      a = (i < addr_log.size()) ? addr_log[i] : 16'hFFFF;
      checks++;
      if (a !== exp_addr[i]) begin
        failures++; $display("FAIL delay_addr[%0d]: got %0h expected %0h", i, a, exp_addr[i]);
      end
    end
  endtask

  task automatic test_calc_hold;
    int c;
    run_frame(16'h0100, 0, 10, 1'b1, 1'b0, 0);
    checks++;
    if (n_stray != 9) begin failures++; $display("FAIL hold_stray: got %0d expected 9", n_stray); end
    checks++;
    if (n_gapbad != 0) begin
      failures++; $display("FAIL hold_gap: got %0d early shifts expected 0", n_gapbad);
    end
    checks++;
    if (n_calc != 4 || n_done != 1 || addr_log.size() != 18) begin
      failures++;
      $display("FAIL hold_counts: got calc %0d done %0d reads %0d expected 4 1 18",
               n_calc, n_done, addr_log.size());
    end
    for (int i = 0; i < 3; i++) begin
      c = (i < dir_log.size()) ? dir_log[i] : -1;
      checks++;
      if (c != exp_dir[i]) begin
        failures++; $display("FAIL hold_dir[%0d]: got %0d expected %0d", i, c, exp_dir[i]);
      end
    end
  endtask

  task automatic test_reset_mid_refill;
    logic [AW-1:0] a;
    run_frame(16'h0100, 0, 0, 1'b0, 1'b0, 10);
    checks++;
    if (mem_rd_req !== 1'b1 || wb_shift_direc !== 2'b01) begin
      failures++;
      $display("FAIL abort_in_refill: got req %b dir %b expected 1 01", mem_rd_req, wb_shift_direc);
    end
    #1 n_rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (all_outs !== '0) begin
      failures++; $display("FAIL abort_outs: got %0h expected 0", all_outs);
    end
    n_rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (all_outs !== '0) begin
      failures++; $display("FAIL abort_residual: got %0h expected 0", all_outs);
    end
    run_frame(16'h0100, 0, 0, 1'b0, 1'b0, 0);
    checks++;
    if (n_done != 1 || addr_log.size() != 18) begin
      failures++;
      $display("FAIL rescan_counts: got done %0d reads %0d expected 1 18", n_done, addr_log.size());
    end
    for (int i = 0; i < 18; i++) begin
      a = (i < addr_log.size()) ? addr_log[i] : 16'hFFFF;
      checks++;
      if (a !== exp_addr[i]) begin
        failures++; $display("FAIL rescan_addr[%0d]: got %0h expected %0h", i, a, exp_addr[i]);
      end
    end
  endtask

  task automatic test_busy_restart;
    logic [AW-1:0] a;
    run_frame(16'h0100, 0, 0, 1'b0, 1'b1, 0);
    checks++;
    if (n_restart != 1) begin
      failures++; $display("FAIL restart_pulsed: got %0d expected 1", n_restart);
    end
    checks++;
    if (n_done != 1 || n_calc != 4 || addr_log.size() != 18) begin
      failures++;
      $display("FAIL restart_counts: got done %0d calc %0d reads %0d expected 1 4 18",
               n_done, n_calc, addr_log.size());
    end
    for (int i = 0; i < 18; i++) begin
      a = (i < addr_log.size()) ? addr_log[i] : 16'hFFFF;
      checks++;
      if (a !== exp_addr[i]) begin
        failures++; $display("FAIL restart_addr[%0d]: got %0h expected %0h", i, a, exp_addr[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan_4x4();
    test_single_window();
    test_ack_delay();
    test_calc_hold();
    test_reset_mid_refill();
    test_busy_restart();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/window_scan_ctrl.md
Name: window_scan_ctrl

Overview:
- Sequences the 3x3 Sobel window buffer across one frame in serpentine order: full 9-pixel load, then left/down/right shift plus 3-pixel refill per step.
- Issues pixel read requests to the frame memory and drives start_read, start_shift, shift_direc and count into the window buffer.
- Pulses the Sobel compute stage once per valid window and reports window position and frame completion.

Parameters:
- IMG_W, 8, image width in pixels (>=3)
- IMG_H, 8, image height in pixels (>=3)
- ADDR_W, 16, pixel address width

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle pulse; begin a frame scan (ignored unless IDLE)
- frame_base  in  ADDR_W  base address of pixel (0,0); sampled on frame_start
- mem_rd_req  out  1  read request; held with mem_addr until ack
- mem_addr  out  ADDR_W  pixel address = base + row*IMG_W + col
- mem_rd_ack  in  1  read data valid this cycle; pixel goes straight to buffer data_r
- wb_start_read  out  1  one-cycle pulse, equals mem_rd_req & mem_rd_ack
- wb_start_shift  out  1  one-cycle shift pulse
- wb_shift_direc  out  2  00 full load, 01 left, 10 right, 11 down
- wb_count  out  4  fill index for current read (0..8 full, 0..2 refill)
- calc_start  out  1  one-cycle pulse: window valid, compute
- calc_done  in  1  compute finished; honoured only in WAIT_CALC
- win_row, win_col  out  ADDR_W each  top-left of current window
- busy  out  1  high from accepted frame_start to frame_done
- frame_done  out  1  one-cycle pulse after last window computed

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Reset mid-frame aborts immediately; no residual request.
- States: IDLE, FULL_LOAD, CALC, WAIT_CALC, SHIFT, REFILL, DONE.
- IDLE: on frame_start latch base, win_row=win_col=0, dir=00, count=0; next cycle FULL_LOAD with mem_rd_req=1.
- FULL_LOAD: read k=0..8 at row win_row+k/3, col win_col+k%3; wb_count=k. On ack, pulse wb_start_read and increment k. After k=8 ack go CALC. Request deasserts the cycle after final ack.
- CALC: one cycle, calc_start=1 -> WAIT_CALC.
- WAIT_CALC: wait calc_done. Then:
  - last window (win_row=IMG_H-3 and col at row-end for current sweep) -> DONE;
  - row-end -> dir=11;
  - else even sweep (win_row even) dir=01, odd sweep dir=10.
  - Go SHIFT.
- SHIFT: one cycle wb_start_shift=1, wb_shift_direc=dir; update win_col +1 (01), -1 (10) or win_row +1 (11); go REFILL, k=0.
- REFILL: 3 reads, wb_count=k, dir held:
  - 01: col win_col+2, rows win_row+k;
  - 10: col win_col, rows win_row+k;
  - 11: row win_row+2, cols win_col+k.
  - After third ack go CALC.
- DONE: frame_done pulse one cycle, busy drops, return IDLE.
- wb_start_read and wb_start_shift never high together. wb_shift_direc stable throughout each read sequence.
- Row-end: even sweep win_col=IMG_W-3, odd sweep win_col=0. IMG_W=3 gives only down shifts. IMG_W=IMG_H=3 gives one window, 9 reads.
- Total reads per frame = 9 + 3*((IMG_W-2)*(IMG_H-2)-1). Windows = (IMG_W-2)*(IMG_H-2).
- Address arithmetic is unsigned modulo 2^ADDR_W.
- frame_start while busy ignored. mem_rd_ack with no request ignored. calc_done outside WAIT_CALC ignored.

Decomposition:
- Package sobel_pkg:
  - shift_dir_t enum: DIR_LOAD=00, DIR_LEFT=01, DIR_RIGHT=10, DIR_DOWN=11;
  - scan_state_t enum;
  - FULL_FILL=9 and REFILL=3 constants.
- Sub-module scan_addr_gen (combinational): base, win_row, win_col, dir, k -> mem_addr.

Test Plan:
- 4x4, base 0x100, ack every cycle -> full-load addresses 0x100,101,102,104,105,106,108,109,10A with wb_count 0..8. Left refill 0x103,107,10B. Down refill 0x10D,10E,10F. Right refill 0x104,108,10C. 4 calc_start, 18 reads, then frame_done.
- 3x3 frame -> 9 reads, one calc_start, no wb_start_shift, frame_done.
- 4x4 with ack delayed 3 cycles per read -> mem_addr/wb_count stable while waiting; wb_start_read only on ack cycles; same address sequence.
- calc_done held off 10 cycles; stray calc_done during FULL_LOAD -> no shift until real done; stray ignored.
- n_rst low mid-REFILL -> all outputs 0 next edge. Fresh frame_start rescans from (0,0).
- frame_start pulsed while busy -> no restart; base unchanged; sequence completes normally.
